// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared seven-segment constants and lookup
// Segment words are active-low, bit0 = a ... bit6 = g.
package hex_disp_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Index 15 is written first so SEG_TABLE[n] yields the glyph for nibble n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   function automatic seg_t seg_lookup(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - combinational nibble to active-low segment decode
// Ports: nibble (in, 4) value to show; seg (out, 7) active-low segments a..g.
module hex7seg_decode
   import hex_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   assign seg = seg_lookup(nibble);

endmodule

// File: rtl/hex_display_bank.sv
// rtl/hex_display_bank.sv - multi-digit hex display driver with entry, blanking and blink
// Ports: clk, reset (sync, active-high); clear/load/shift commands with value_in
// and nibble_in; blank_lz and blink_mask display controls; value_out, sticky
// overflow and registered active-low hex_out (digit i at [7i+6:7i]).
module hex_display_bank
   import hex_disp_pkg::*;
#(
   parameter int DIGITS    = 6,
   parameter int BLINK_DIV = 25_000_000
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic                  shift,
   input  logic [3:0]            nibble_in,
   input  logic                  blank_lz,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [4*DIGITS-1:0]   value_out,
   output logic                  overflow,
   output logic [7*DIGITS-1:0]   hex_out
);

   localparam int VW    = 4 * DIGITS;
   localparam int HW    = 7 * DIGITS;
   localparam int CNT_W = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

   logic [VW-1:0]    value_q, value_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [HW-1:0]    hex_q, hex_d;

   seg_t             seg [DIGITS];
   logic             upper_zero;
   logic [DIGITS-1:0] blank;

   // Value register and overflow flag; priority clear > load > shift.
   always_comb begin
      value_d    = value_q;
      overflow_d = overflow_q;
      if (clear) begin
         value_d    = '0;
         overflow_d = 1'b0;
      end else if (load) begin
         value_d    = value_in;
         overflow_d = 1'b0;
      end else if (shift) begin
         // Truncating cast drops the old top digit; also covers DIGITS = 1.
         value_d = VW'({value_q, nibble_in});
         if (value_q[VW-1 -: 4] != 4'h0) begin
            overflow_d = 1'b1;
         end
      end
   end

   // Free-running blink timer, independent of the value commands.
   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      hex7seg_decode u_dec (
         .nibble (value_q[4*g +: 4]),
         .seg    (seg[g])
      );
   end

   // Walk from the top digit down; upper_zero stays set while every digit
   // seen so far is zero. Digit 0 never takes the leading-zero blank.
   always_comb begin
      hex_d      = '0;
      blank      = '0;
      upper_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero = upper_zero & (value_q[4*i +: 4] == 4'h0);
         blank[i]   = (blank_lz & upper_zero & (i != 0)) | (blink_mask[i] & phase_q);
         hex_d[7*i +: 7] = blank[i] ? SEG_BLANK : seg[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q    <= '0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         hex_q      <= {DIGITS{SEG_BLANK}};
      end else begin
         value_q    <= value_d;
         overflow_q <= overflow_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         hex_q      <= hex_d;
      end
   end

   assign value_out = value_q;
   assign overflow  = overflow_q;
   assign hex_out   = hex_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// tb/tb_hex_display_bank.sv - self-checking bench for hex_display_bank
module tb_hex_display_bank;

   localparam int ND  = 6;
   localparam int DIV = 4;

   logic            clk = 1'b0;
   logic            reset, clear, load, shift, blank_lz;
   logic [23:0]     value_in;
   logic [3:0]      nibble_in;
   logic [5:0]      blink_mask;
   logic [23:0]     value_out;
   logic            overflow;
   logic [41:0]     hex_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hex_display_bank #(.DIGITS(ND), .BLINK_DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .load       (load),
      .value_in   (value_in),
      .shift      (shift),
      .nibble_in  (nibble_in),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .value_out  (value_out),
      .overflow   (overflow),
      .hex_out    (hex_out)
   );

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [41:0] render(input logic [23:0] v, input logic lz,
                                          input logic [5:0] m, input int ph);
      logic [41:0] r;
      logic [3:0]  nib;
      logic        blk;
      r = '0;
      for (int i = 0; i < ND; i++) begin
         nib = 4'((v >> (4*i)) & 24'hF);
         blk = (lz && i != 0 && (v >> (4*i)) == 24'h0) || (m[i] && ph == 1);
         r[7*i +: 7] = blk ? 7'h7F : glyph[nib];
      end
      return r;
   endfunction

   // Reference model: value/overflow from the command rules, blink phase from
   // the number of edges since reset, hex from the state before the edge.
   logic [23:0] m_val;
   logic        m_ovf;
   logic [41:0] m_hex;
   int          m_cyc;
   bit          m_valid = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_val   = '0;
         m_ovf   = 1'b0;
         m_cyc   = 0;
         m_hex   = {ND{7'h7F}};
         m_valid = 1;
      end else if (m_valid) begin
         m_hex = render(m_val, blank_lz, blink_mask, (m_cyc / DIV) % 2);
         if (clear) begin
            m_val = '0;
            m_ovf = 1'b0;
         end else if (load) begin
            m_val = value_in;
            m_ovf = 1'b0;
         end else if (shift) begin
            if ((m_val >> 20) != 0) m_ovf = 1'b1;
            m_val = ((m_val << 4) | 24'(nibble_in)) & 24'hFFFFFF;
         end
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("value_out", 64'(value_out), 64'(m_val));
         check("overflow",  64'(overflow),  64'(m_ovf));
         check("hex_out",   64'(hex_out),   64'(m_hex));
      end
   end

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   task automatic idle();
      clear = 0; load = 0; shift = 0;
   endtask

   int cnt79, cnt7f;
   logic [34:0] upper_ref;
   bit upper_ok;

   initial begin
      reset = 1; clear = 0; load = 0; shift = 0; blank_lz = 0;
      value_in = '0; nibble_in = '0; blink_mask = '0;
      step(2);
      check("rst_value", 64'(value_out), 64'h0);
      check("rst_ovf",   64'(overflow),  64'h0);
      check("rst_hex",   64'(hex_out),   64'({6{7'h7F}}));
      reset = 0;
      step(2);
      check("idle_hex_zeros", 64'(hex_out), 64'({6{7'h40}}));
      check("idle_ovf", 64'(overflow), 64'h0);

      blank_lz = 1; value_in = 24'h00A3F0; load = 1;
      step();
      check("load_value", 64'(value_out), 64'h00A3F0);
      idle();
      step();
      check("load_hex", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h40}));
      value_in = 24'h0; load = 1;
      step(); idle(); step();
      check("zero_hex_lz", 64'(hex_out), 64'({{5{7'h7F}}, 7'h40}));

      clear = 1; step(); idle();
      for (int k = 1; k <= 7; k++) begin
         shift = 1; nibble_in = 4'(k);
         step();
      end
      idle();
      check("shift_value", 64'(value_out), 64'h234567);
      check("shift_ovf",   64'(overflow),  64'h1);
      value_in = 24'h000042; load = 1;
      step(); idle();
      check("load_clears_ovf", 64'(overflow), 64'h0);

      clear = 1; load = 1; shift = 1; value_in = 24'h777777; nibble_in = 4'h9;
      step();
      check("prio_clear", 64'(value_out), 64'h0);
      clear = 0; value_in = 24'h13579B;
      step(); idle();
      check("prio_load", 64'(value_out), 64'h13579B);

      blank_lz = 0; blink_mask = 6'b000001; value_in = 24'h1; load = 1;
      step(); idle(); step();
      cnt79 = 0; cnt7f = 0; upper_ok = 1; upper_ref = {5{7'h40}};
      for (int k = 0; k < 16; k++) begin
         if (hex_out[6:0] == 7'h79) cnt79++;
         if (hex_out[6:0] == 7'h7F) cnt7f++;
         if (hex_out[41:7] != upper_ref) upper_ok = 0;
         step();
      end
      check("blink_on_count",  64'(cnt79), 64'd8);
      check("blink_off_count", 64'(cnt7f), 64'd8);
      check("blink_upper_steady", 64'(upper_ok), 64'h1);

      for (int k = 0; k < 5; k++) begin
         shift = 1; nibble_in = 4'($urandom_range(1, 15));
         step();
      end
      reset = 1;
      step();
      check("midrst_value", 64'(value_out), 64'h0);
      check("midrst_ovf",   64'(overflow),  64'h0);
      check("midrst_hex",   64'(hex_out),   64'({6{7'h7F}}));
      reset = 0; idle();
      step(4);
      check("restart_phase0", 64'(hex_out[6:0]), 64'h40);
      step();
      check("restart_phase1", 64'(hex_out[6:0]), 64'h7F);

      for (int k = 0; k < 1500; k++) begin
         reset     = ($urandom_range(0, 99) < 2);
         clear     = ($urandom_range(0, 19) == 0);
         load      = ($urandom_range(0, 9) == 0);
         shift     = ($urandom_range(0, 1) == 1);
         nibble_in = 4'($urandom_range(0, 15));
         value_in  = 24'($urandom >> $urandom_range(8, 31));
         if (k % 40 == 0) begin
            blank_lz   = 1'($urandom_range(0, 1));
            blink_mask = 6'($urandom_range(0, 63));
         end
         step();
      end
      reset = 0; idle();
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
